// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported word memory between instruction fetch and data load/store.
// Optional WAIT-state timeout with sticky err flag: define ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:2] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:2] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_cen,
    output logic        mem_wen,
    output logic [31:2] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    output logic        err
);

    // state   | meaning
    // S_IDLE  | arbitrate pending requests, latch the winner
    // S_ISSUE | one-cycle memory strobe
    // S_WAIT  | wait out mem_stall, capture read data
    // S_RESP  | ready pulse to the granted port
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  streak_q;
    logic        gnt_d_q;
    logic [31:0] rdata_q;
    logic        any_req, pick_d, timeout;
    logic        cen_nxt, i_rdy_nxt, d_rdy_nxt;

    assign any_req = i_req | d_req;
    assign pick_d  = d_req & ~(i_req & (streak_q == LIMIT));

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt_q;
    logic          err_q;

    // Down-counter reloaded in ISSUE so it starts full on WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            wait_cnt_q <= TW'(TIMEOUT_CYC - 1);
        end else if (state_q == S_WAIT && wait_cnt_q != '0) begin
            wait_cnt_q <= wait_cnt_q - TW'(1);
        end
    end

    assign timeout = (state_q == S_WAIT) && mem_stall && (wait_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (!mem_stall || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the upcoming state.
    always_comb begin
        cen_nxt   = (state_d == S_ISSUE);
        i_rdy_nxt = (state_d == S_RESP) && !gnt_d_q;
        d_rdy_nxt = (state_d == S_RESP) && gnt_d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cen   <= 1'b0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            gnt_d_q   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            streak_q  <= '0;
            rdata_q   <= '0;
        end else begin
            mem_cen <= cen_nxt;
            i_ready <= i_rdy_nxt;
            d_ready <= d_rdy_nxt;
            if (state_q == S_IDLE && any_req) begin
                gnt_d_q   <= pick_d;
                mem_addr  <= pick_d ? d_addr : i_addr;
                mem_wen   <= pick_d & d_wen;
                mem_wdata <= pick_d ? d_wdata : '0;
                streak_q  <= (pick_d && i_req) ? streak_q + 4'd1 : 4'd0;
            end
            // A write, or a timed-out access (still stalled), returns zero.
            if (state_q == S_WAIT && state_d == S_RESP) begin
                rdata_q <= (mem_wen || mem_stall) ? 32'd0 : mem_rdata;
            end
        end
    end

    assign i_rdata = rdata_q;
    assign d_rdata = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported, word-addressed memory between the instruction-fetch path and the data load/store path of the core. Each access is sequenced through a fixed issue/wait/respond handshake, and memory stalls are absorbed. Requesters see one registered `*_ready` pulse per completed access. The block sits between the fetch/decode front end, the load/store unit and the memory macro.

## Interface
- `STARVE_LIMIT`, 4: max consecutive data grants while `i_req` pends before instruction is forced; legal range 1..15
- `TIMEOUT_CYC`, 64: WAIT-state cycle limit; used only with `ARB_TIMEOUT_EN`
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `i_req` in 1: instruction read request, held until `i_ready`
- `i_addr` in [31:2]: instruction word address
- `i_rdata` out 32: instruction read data, valid while `i_ready`=1
- `i_ready` out 1: one-cycle completion pulse, instruction port
- `d_req` in 1: data request, held until `d_ready`
- `d_wen` in 1: 1 = write, 0 = read
- `d_addr` in [31:2]: data word address
- `d_wdata` in 32: write data
- `d_rdata` out 32: data read data, valid while `d_ready`=1
- `d_ready` out 1: one-cycle completion pulse, data port
- `mem_cen` out 1: memory access strobe, exactly one cycle per access
- `mem_wen` out 1: memory write enable, qualified by `mem_cen`
- `mem_addr` out [31:2]: memory word address
- `mem_wdata` out 32: memory write data
- `mem_rdata` in 32: memory read data, valid when `mem_stall`=0 in WAIT
- `mem_stall` in 1: memory busy
- `err` out 1: sticky timeout flag

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If either request is high, arbitrate.
  - Latch the grant (I/D), address, wen and wdata into internal registers.
  - Go to ISSUE.
- Arbitration:
  - `d_req` alone grants D. `i_req` alone grants I.
  - When both are high, D wins, unless `streak` == `STARVE_LIMIT`; then I wins.
- Streak counter:
  - Increments on a D grant made while `i_req`=1.
  - Clears on any I grant.
  - Clears on a D grant made with `i_req`=0.
- ISSUE:
  - `mem_cen`=1 for one cycle.
  - `mem_wen`/`mem_addr`/`mem_wdata` are driven from the latched registers; they hold the latched values at all other times.
  - Next state: WAIT.
- WAIT:
  - If `mem_stall`=1, stay.
  - If `mem_stall`=0, capture `mem_rdata` into the shared rdata register (0 for writes) and go to RESP.
- RESP:
  - Assert `i_ready` or `d_ready` for the granted port only.
  - Both `i_rdata` and `d_rdata` drive the shared register; each is valid only while its own ready is high.
  - Next state: IDLE.
- Requesters may drop `*_req` in the ready cycle, or hold it high to request a new access, which is arbitrated in the following IDLE cycle.
- Inputs are sampled only in IDLE. Changes to `*_addr`/`*_wdata` after the grant have no effect.
- Reset asserted at any time:
  - FSM returns to IDLE.
  - `streak` and the rdata register clear.
  - The in-flight access is abandoned and no ready pulse is issued.
  - `err` clears.

## Timing
- Reset value of every output is 0: `i_rdata`, `d_rdata`, `i_ready`, `d_ready`, `mem_cen`, `mem_wen`, `mem_addr`, `mem_wdata`, `err`.
- All outputs are registered.
- Request sampled in IDLE at cycle T:
  - `mem_cen` at T+1.
  - Capture at T+2 when `mem_stall`=0.
  - Ready at T+3.
- Each cycle of `mem_stall`=1 in WAIT adds one cycle of latency.
- `mem_stall` is ignored outside WAIT.
- Back-to-back throughput is one access per 4 cycles, since IDLE always costs one cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A WAIT counter clears on entry to WAIT.
  - If `mem_stall` is still 1 after `TIMEOUT_CYC` WAIT cycles, set `err`=1 (sticky until reset), force the rdata register to 0, go to RESP and issue the ready pulse normally.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT persists indefinitely.
  - `err` is tied to 0.
  - `TIMEOUT_CYC` is unused.

## Test plan
- Fetch with zero stall: `i_req`=1, `i_addr`=0x10 at T, `mem_rdata`=0x00500093 -> `mem_cen`=1 with `mem_addr`=0x10 at T+1; `i_ready`=1 with `i_rdata`=0x00500093 at T+3, one cycle only.
- Simultaneous requests: `i_req`=`d_req`=1, D write to 0x20 of 0xCAFEF00D -> D serviced first (`mem_wen`=1, `d_ready` at T+3, `d_rdata`=0); I issued at T+5, `i_ready` at T+7.
- Starvation: `d_req` held high continuously and `i_req`=1, `STARVE_LIMIT`=4 -> four D accesses, then the fifth grant goes to I; afterwards D resumes.
- Stall: `mem_stall`=1 for 5 WAIT cycles -> ready at T+8; `mem_cen` high only at T+1.
- Reset in WAIT: deassert `rst_n` at T+2 of a D read -> no `d_ready`; all outputs 0; a new `i_req` after reset completes in 3 cycles.
- Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=64): `mem_stall` held at 1 -> `err`=1 and ready with rdata 0 after 64 WAIT cycles; `err` stays 1 across later accesses until reset.
